// File: rtl/trace_req_queue.sv
// Timed trace-record queue: buffers parsed trace records and releases each one
// to the controller front-end once the CPU-time counter reaches its timestamp.
module trace_req_queue #(
    parameter int MEM_ADDR_WIDTH = 64,
    parameter int TIME_WIDTH     = 32,
    parameter int CPU_CORE_WIDTH = 4,
    parameter int MEM_OPN_WIDTH  = 3,
    parameter int DEPTH          = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [TIME_WIDTH-1:0]       in_time,
    input  logic [CPU_CORE_WIDTH-1:0]   in_core,
    input  logic [MEM_OPN_WIDTH-1:0]    in_opn,
    input  logic [MEM_ADDR_WIDTH-1:0]   in_addr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TIME_WIDTH-1:0]       out_time,
    output logic [CPU_CORE_WIDTH-1:0]   out_core,
    output logic [MEM_OPN_WIDTH-1:0]    out_opn,
    output logic [MEM_ADDR_WIDTH-1:0]   out_addr,
    output logic [TIME_WIDTH-1:0]       cur_time,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty,
    input  logic                        skip_idle,
    output logic                        err_illegal_opn,
    output logic                        err_order,
    input  logic                        err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [TIME_WIDTH-1:0]     t;
        logic [CPU_CORE_WIDTH-1:0] core;
        logic [MEM_OPN_WIDTH-1:0]  opn;
        logic [MEM_ADDR_WIDTH-1:0] addr;
    } rec_t;

    rec_t                  mem [DEPTH];
    rec_t                  head;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [TIME_WIDTH-1:0] last_time;
    logic                  push, legal, wr, pop, ff_jump;

    assign head      = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = !empty && (head.t <= cur_time);
    assign out_time  = head.t;
    assign out_core  = head.core;
    assign out_opn   = head.opn;
    assign out_addr  = head.addr;

    // Illegal opcodes still complete the handshake; they are simply dropped.
    assign push    = in_valid && in_ready;
    assign legal   = (in_opn <= MEM_OPN_WIDTH'(2));
    assign wr      = push && legal;
    assign pop     = out_valid && out_ready;
    assign ff_jump = skip_idle && !empty && (head.t > cur_time);

    // Storage needs no reset: contents are only observed behind a valid count.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= '{t: in_time, core: in_core, opn: in_opn, addr: in_addr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            cur_time        <= '0;
            last_time       <= '0;
            err_illegal_opn <= 1'b0;
            err_order       <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            cur_time <= ff_jump ? head.t : cur_time + 1'b1;
            if (wr) last_time <= in_time;
            // A set condition in the same cycle as err_clr takes priority.
            if (push && !legal)                err_illegal_opn <= 1'b1;
            else if (err_clr)                  err_illegal_opn <= 1'b0;
            if (wr && (in_time < last_time))   err_order <= 1'b1;
            else if (err_clr)                  err_order <= 1'b0;
        end
    end
endmodule

// File: tb/tb_trace_req_queue.sv
// Bench for trace_req_queue: directed table, hand-written corner sequences and
// random traffic, all scored against a queue-based reference model.
module tb_trace_req_queue;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [31:0] in_time = 0, out_time, cur_time;
    logic [3:0]  in_core = 0, out_core;
    logic [2:0]  in_opn = 0, out_opn;
    logic [63:0] in_addr = 0, out_addr;
    logic [4:0]  count;
    logic        full, empty, skip_idle = 0, err_illegal_opn, err_order, err_clr = 0;

    trace_req_queue #(.MEM_ADDR_WIDTH(64), .TIME_WIDTH(32), .CPU_CORE_WIDTH(4),
                      .MEM_OPN_WIDTH(3), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_time(in_time), .in_core(in_core), .in_opn(in_opn), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_time(out_time),
        .out_core(out_core), .out_opn(out_opn), .out_addr(out_addr),
        .cur_time(cur_time), .count(count), .full(full), .empty(empty),
        .skip_idle(skip_idle), .err_illegal_opn(err_illegal_opn),
        .err_order(err_order), .err_clr(err_clr));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] t; logic [3:0] core; logic [2:0] opn; logic [63:0] addr;
    } rec_t;

    typedef struct {
        logic vld; logic [31:0] t; logic [3:0] core; logic [2:0] opn; logic [63:0] addr;
        logic ordy; logic clr;
        logic e_ovld; int e_cnt; logic [31:0] e_time; logic e_ill; logic e_ord;
    } vec_t;

    int checks = 0, failures = 0;

    // Reference model state
    rec_t        mq[$];
    logic [31:0] m_time, m_last;
    logic        m_ill, m_ord;
    logic [63:0] popped[$];

    // Values observed in the most recent step
    logic        o_ovld, o_rdy, o_full;
    int          o_cnt;
    logic [31:0] o_time, o_otime;
    logic        o_ill, o_ord;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic vld, logic [31:0] t, logic [3:0] core, logic [2:0] opn,
                                logic [63:0] addr, logic ordy, logic clr, logic e_ovld,
                                int e_cnt, logic [31:0] e_time, logic e_ill, logic e_ord);
        vec_t v;
        v.vld = vld; v.t = t; v.core = core; v.opn = opn; v.addr = addr;
        v.ordy = ordy; v.clr = clr; v.e_ovld = e_ovld; v.e_cnt = e_cnt;
        v.e_time = e_time; v.e_ill = e_ill; v.e_ord = e_ord;
        return v;
    endfunction

    task automatic model_clear();
        mq.delete(); m_time = 0; m_last = 0; m_ill = 0; m_ord = 0;
    endtask

    // One clock cycle: inputs already driven; compare at negedge, advance model.
    task automatic step();
        int sz; logic m_ovld, s_ill, s_ord; logic [31:0] nt;
        @(negedge clk);
        sz = mq.size();
        m_ovld = 0;
        if (sz > 0) m_ovld = (mq[0].t <= m_time);
        chk("in_ready", in_ready, sz < DEPTH);
        chk("out_valid", out_valid, m_ovld);
        chk("count", count, sz);
        chk("full", full, sz == DEPTH);
        chk("empty", empty, sz == 0);
        chk("cur_time", cur_time, m_time);
        chk("err_illegal_opn", err_illegal_opn, m_ill);
        chk("err_order", err_order, m_ord);
        if (m_ovld) begin
            chk("out_time", out_time, mq[0].t);
            chk("out_core", out_core, mq[0].core);
            chk("out_opn", out_opn, mq[0].opn);
            chk("out_addr", out_addr, mq[0].addr);
        end
        o_ovld = out_valid; o_rdy = in_ready; o_full = full; o_cnt = int'(count);
        o_time = cur_time; o_otime = out_time; o_ill = err_illegal_opn; o_ord = err_order;
        nt = m_time + 1;
        if (skip_idle && sz > 0) if (mq[0].t > m_time) nt = mq[0].t;
        if (m_ovld && out_ready) begin
            popped.push_back(out_addr);
            void'(mq.pop_front());
        end
        s_ill = 0; s_ord = 0;
        if (in_valid && sz < DEPTH) begin
            if (in_opn > 2) s_ill = 1;
            else begin
                if (in_time < m_last) s_ord = 1;
                m_last = in_time;
                mq.push_back('{t: in_time, core: in_core, opn: in_opn, addr: in_addr});
            end
        end
        m_ill = s_ill | (m_ill & !err_clr);
        m_ord = s_ord | (m_ord & !err_clr);
        m_time = nt;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_time = 0; in_core = 0; in_opn = 0; in_addr = 0;
        out_ready = 0; skip_idle = 0; err_clr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cur_time", cur_time, 0);
        chk("rst_errs", {err_illegal_opn, err_order}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        popped.delete();
    endtask

    task automatic push_in(input logic [31:0] t, input logic [3:0] c, input logic [2:0] o,
                           input logic [63:0] a);
        in_valid = 1; in_time = t; in_core = c; in_opn = o; in_addr = a;
    endtask

    vec_t tbl[16];

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog simulation did not finish, actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_inputs();
        model_clear();
        #2;
        do_reset();

        // Timed release, illegal opcode and order error; cur_time == row index.
        tbl[0]  = mk(1,   5, 1, 0, 64'h1000, 1, 0,  0, 0,  0, 0, 0);
        tbl[1]  = mk(0,   0, 0, 0, 0,        1, 0,  0, 1,  1, 0, 0);
        tbl[2]  = mk(0,   0, 0, 0, 0,        1, 0,  0, 1,  2, 0, 0);
        tbl[3]  = mk(0,   0, 0, 0, 0,        1, 0,  0, 1,  3, 0, 0);
        tbl[4]  = mk(0,   0, 0, 0, 0,        1, 0,  0, 1,  4, 0, 0);
        tbl[5]  = mk(0,   0, 0, 0, 0,        1, 0,  1, 1,  5, 0, 0);
        tbl[6]  = mk(0,   0, 0, 0, 0,        1, 0,  0, 0,  6, 0, 0);
        tbl[7]  = mk(1,   7, 2, 5, 64'hdead, 0, 0,  0, 0,  7, 0, 0);
        tbl[8]  = mk(1,   8, 3, 2, 64'h2000, 0, 0,  0, 0,  8, 1, 0);
        tbl[9]  = mk(0,   0, 0, 0, 0,        0, 1,  1, 1,  9, 1, 0);
        tbl[10] = mk(0,   0, 0, 0, 0,        0, 0,  1, 1, 10, 0, 0);
        tbl[11] = mk(0,   0, 0, 0, 0,        1, 0,  1, 1, 11, 0, 0);
        tbl[12] = mk(0,   0, 0, 0, 0,        0, 0,  0, 0, 12, 0, 0);
        tbl[13] = mk(1, 100, 4, 0, 64'h3000, 1, 0,  0, 0, 13, 0, 0);
        tbl[14] = mk(1,  50, 5, 1, 64'h4000, 1, 0,  0, 1, 14, 0, 0);
        tbl[15] = mk(0,   0, 0, 0, 0,        1, 0,  0, 2, 15, 0, 1);
        for (int i = 0; i < 16; i++) begin
            in_valid = tbl[i].vld; in_time = tbl[i].t; in_core = tbl[i].core;
            in_opn = tbl[i].opn; in_addr = tbl[i].addr;
            out_ready = tbl[i].ordy; err_clr = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_out_valid", i), o_ovld, tbl[i].e_ovld);
            chk($sformatf("tbl%0d_count", i), o_cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_cur_time", i), o_time, tbl[i].e_time);
            chk($sformatf("tbl%0d_err_ill", i), o_ill, tbl[i].e_ill);
            chk($sformatf("tbl%0d_err_ord", i), o_ord, tbl[i].e_ord);
        end
        chk("release_popped_1000", popped[0], 64'h1000);

        // Head at t=100 blocks the t=50 record until cur_time reaches 100.
        idle_inputs(); out_ready = 1;
        n = 0;
        do begin step(); n++; end while (!o_ovld && n < 200);
        chk("order_head_release_time", o_time, 100);
        chk("order_head_out_time", o_otime, 100);
        step();
        chk("order_second_valid", o_ovld, 1);
        chk("order_second_out_time", o_otime, 50);
        err_clr = 1; step(); err_clr = 0; step();
        chk("order_cleared", o_ord, 0);

        // Full / backpressure
        idle_inputs(); do_reset();
        for (int i = 0; i < 16; i++) begin push_in(0, 4'(i), 3'(i % 3), 64'(i)); step(); end
        push_in(0, 0, 1, 64'd16);
        step();
        chk("bp_full_after16", o_full, 1);
        chk("bp_in_ready_low", o_rdy, 0);
        step();
        chk("bp_held_count", o_cnt, 16);
        out_ready = 1;
        step();
        chk("bp_ready_low_on_first_pop", o_rdy, 0);
        step();
        chk("bp_17th_accepted", o_rdy, 1);
        in_valid = 0;
        for (int i = 0; i < 20; i++) step();
        chk("bp_drain_total", popped.size(), 17);
        foreach (popped[i]) chk($sformatf("bp_drain_order%0d", i), popped[i], i);

        // Continuous stream across pointer wrap
        idle_inputs(); do_reset();
        out_ready = 1;
        for (int i = 0; i < 40; i++) begin
            push_in(0, 4'(i), 3'(i % 3), 64'(100 + i));
            step();
            chk("wrap_count_le1", o_cnt <= 1, 1);
        end
        in_valid = 0; step(); step();
        chk("wrap_total", popped.size(), 40);
        foreach (popped[i]) chk($sformatf("wrap_order%0d", i), popped[i], 100 + i);

        // Fast-forward, then asynchronous reset with entries queued
        idle_inputs(); do_reset();
        skip_idle = 1;
        step(); step(); step();
        push_in(1000, 7, 0, 64'h5000);
        step();
        chk("ff_push_time", o_time, 3);
        in_valid = 0;
        step();
        chk("ff_before_jump_valid", o_ovld, 0);
        push_in(1000, 1, 1, 64'h5001); step();
        chk("ff_jumped_time", o_time, 1000);
        chk("ff_valid", o_ovld, 1);
        push_in(1001, 2, 2, 64'h5002); step();
        in_valid = 0; step();
        chk("ff_three_queued", o_cnt, 3);
        @(negedge clk);
        do_reset();

        // Random traffic against the model
        idle_inputs();
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_core   = 4'($urandom);
            in_opn    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            in_addr   = {$urandom, $urandom};
            if (m_last > 10 && $urandom_range(0, 9) == 0) in_time = m_last - $urandom_range(1, 10);
            else in_time = m_last + $urandom_range(0, 12);
            out_ready = ($urandom_range(0, 9) < 6);
            skip_idle = ($urandom_range(0, 4) == 0);
            err_clr   = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trace_req_queue.md
Name: trace_req_queue

Overview:
- Parametrised, synthesizable successor to the trace-file ingest stage of the DDR5 memory-controller model.
- Accepts parsed trace records {CPU time, core, operation, address} over a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Releases each record to the controller front-end only when the internal CPU-time counter has reached the record's timestamp.
- Adds operation legality checks, timestamp-order checking, and an idle fast-forward mode.

Parameters:
- MEM_ADDR_WIDTH, 64, request address width.
- TIME_WIDTH, 32, CPU-time counter and timestamp width.
- CPU_CORE_WIDTH, 4, core ID width.
- MEM_OPN_WIDTH, 3, operation code width; legal codes are 0 (data read), 1 (data write), 2 (instruction fetch).
- DEPTH, 16, FIFO entries; must be a power of two, ≥2.

Ports:
- clk  in  1  CPU clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  record offered.
- in_ready  out  1  queue can accept.
- in_time  in  TIME_WIDTH  record timestamp.
- in_core  in  CPU_CORE_WIDTH  record core.
- in_opn  in  MEM_OPN_WIDTH  record operation.
- in_addr  in  MEM_ADDR_WIDTH  record address.
- out_valid  out  1  head record due.
- out_ready  in  1  consumer accepts.
- out_time, out_core, out_opn, out_addr  out  per field  head record fields.
- cur_time  out  TIME_WIDTH  current CPU time.
- count  out  $clog2(DEPTH)+1  stored entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- skip_idle  in  1  fast-forward enable.
- err_illegal_opn  out  1  sticky; illegal opcode seen.
- err_order  out  1  sticky; non-monotonic timestamp seen.
- err_clr  in  1  clears both sticky errors.

Behaviour:
- Reset (async assert, sync release): cur_time=0, count=0, empty=1, full=0, in_ready=1, out_valid=0, errors=0, last-accepted-time register=0, FIFO pointers=0.
- Output fields are undefined while empty; the bench checks them only when out_valid=1.
- in_ready = !full, combinational from registered count. There is no bypass: a push while full is impossible.
- Push occurs on in_valid && in_ready.
  - If in_opn > 2: the record is consumed (handshake completes), not stored, and err_illegal_opn is set next cycle.
  - Otherwise the record is written at the tail and count increments.
- Order check applies to legal pushes only. If in_time < last_time (unsigned), err_order is set; the record is still stored. last_time is then updated to in_time.
- out_valid = !empty && (head.time <= cur_time), unsigned compare, combinational from registered state. out_* always reflect the head entry.
- Pop occurs on out_valid && out_ready; the head advances.
- Minimum latency is 1 cycle: a record pushed in cycle N can pop no earlier than cycle N+1.
- Simultaneous legal push and pop: count is unchanged and both pointers advance.
- Pop and illegal push in the same cycle: count decrements.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- cur_time increments by 1 every cycle, wrapping modulo 2^TIME_WIDTH. The compare does not handle wrap; trace timestamps are absolute and must stay below 2^TIME_WIDTH.
- Fast-forward: if skip_idle && !empty && head.time > cur_time, then cur_time <= head.time on the next cycle instead of incrementing. out_valid for that head asserts in the following cycle.
- Errors: err_clr clears both flags next cycle. If a set condition coincides with err_clr, set wins.
- Reset mid-operation discards all entries and errors; outputs return to reset values immediately (asynchronously).
- The block contains no file I/O. A testbench wrapper performs file parsing, DEBUG-mode printing, and drives the in_* port.

Test Plan:
- Timed release: after reset, push {time=5, core=1, opn=0, addr=0x1000} at cycle 0 with out_ready=1.
  - out_valid stays 0 until cur_time==5, then asserts for 1 cycle with addr=0x1000; count returns to 0.
- Full/backpressure: DEPTH=16, out_ready=0, push 17 records with time=0.
  - full=1 and in_ready=0 after the 16th; the 17th is held.
  - Raising out_ready drains the records in order; the 17th is accepted the cycle after the first pop.
- Wrap/simultaneous: stream 40 records with time=0 while out_ready=1 continuously.
  - count stays ≤1, the output order equals the input order, and no record is lost across pointer wrap.
- Illegal opcode: push opn=5 then opn=2.
  - The first handshake completes, err_illegal_opn=1, and count=1 holding only the opn=2 record.
  - err_clr clears the flag.
- Order error: push times 100 then 50.
  - err_order=1 after the second push. Both records are stored; the head (100) blocks the 50 record until cur_time≥100.
- Fast-forward and reset: skip_idle=1, push time=1000 at cur_time=3.
  - cur_time jumps to 1000 and out_valid=1 one cycle later.
  - Asserting rst_n=0 with 3 entries queued immediately gives count=0, empty=1, cur_time=0.
